// File: rtl/buzzer_pkg.sv
// buzzer_pkg: FSM states, channel codes and helper functions shared by the alarm stages
package buzzer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam logic [1:0] CH_NONE = 2'd0;
    localparam logic [1:0] CH_1    = 2'd1;
    localparam logic [1:0] CH_2    = 2'd2;
    localparam logic [1:0] CH_3    = 2'd3;

    function automatic logic [1:0] winner(input logic [2:0] a);
        return a[2] ? CH_3 : a[1] ? CH_2 : a[0] ? CH_1 : CH_NONE;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        return a > b ? (a > c ? a : c) : (b > c ? b : c);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle tick every PRESCALE enabled clk cycles; clr restarts the count
module tick_prescaler #(
    parameter int PRESCALE = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick  = ena && cnt_q == CW'(PRESCALE - 1);
    assign cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (ena) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen: alarm channel to piezo square wave with per-channel pitch and beep cadence.
// Defining BUZZER_TONE_GEN_MUTE_EN adds a mute input that silences tone_out only.
module buzzer_tone_gen #(
    parameter int PRESCALE   = 256,
    parameter int TONE_HALF1 = 8,
    parameter int TONE_HALF2 = 6,
    parameter int TONE_HALF3 = 4,
    parameter int BEEP_ON    = 32,
    parameter int BEEP_OFF   = 16,
    parameter int GAP        = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] alarm_in,
`ifdef BUZZER_TONE_GEN_MUTE_EN
    input  logic       mute,
`endif
    output logic       tone_out,
    output logic       beep_out,
    output logic [1:0] chan_out
);

    import buzzer_pkg::*;

    localparam int PH_W = $clog2(max3(BEEP_ON, BEEP_OFF, GAP) + 1);
    localparam int TC_W = $clog2(max3(TONE_HALF1, TONE_HALF2, TONE_HALF3) + 1);

    state_e          state_q, state_d;
    logic [1:0]      chan_q, chan_d, beeps_q, beeps_d, win;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [TC_W-1:0] tc_q, tc_d, half_m1;
    logic [2:0]      chan_mask;
    logic            tone_q, tone_d, beep_q, clr, tick, start, drop;

    tick_prescaler #(.PRESCALE(PRESCALE)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clr   (clr),
        .tick  (tick)
    );

    assign win       = winner(alarm_in);
    assign chan_mask = 3'b001 << (chan_q - 2'd1);
    assign half_m1   = chan_q == CH_3 ? TC_W'(TONE_HALF3 - 1)
                     : chan_q == CH_2 ? TC_W'(TONE_HALF2 - 1) : TC_W'(TONE_HALF1 - 1);
    assign drop      = state_q != IDLE && alarm_in == 3'b000;
    // losing our own bit counts as preemption, so any restart re-evaluates the winner
    assign start     = state_q == IDLE ? win != CH_NONE
                     : win > chan_q || (alarm_in & chan_mask) == 3'b000
                       || (state_q == buzzer_pkg::GAP && tick && ph_q == PH_W'(GAP - 1));

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        beeps_d = beeps_q;
        ph_d    = ph_q;
        tc_d    = tc_q;
        tone_d  = tone_q;
        clr     = 1'b0;
        if (ena) begin
            if (drop) begin
                state_d = IDLE;
                chan_d  = CH_NONE;
                beeps_d = '0;
                ph_d    = '0;
                tc_d    = '0;
                tone_d  = 1'b0;
                clr     = 1'b1;
            end else if (start) begin
                state_d = ON;
                chan_d  = win;
                beeps_d = '0;
                ph_d    = '0;
                tc_d    = '0;
                tone_d  = 1'b1;
                clr     = 1'b1;
            end else if (tick && state_q != IDLE) begin
                ph_d = ph_q + 1'b1;
                if (state_q == ON) begin
                    tc_d   = tc_q == half_m1 ? '0 : tc_q + 1'b1;
                    tone_d = tone_q ^ (tc_q == half_m1);
                    if (ph_q == PH_W'(BEEP_ON - 1)) begin
                        ph_d    = '0;
                        tc_d    = '0;
                        tone_d  = 1'b0;
                        beeps_d = beeps_q + 2'd1;
                        state_d = beeps_q + 2'd1 == chan_q ? buzzer_pkg::GAP : OFF;
                    end
                end else if (state_q == OFF && ph_q == PH_W'(BEEP_OFF - 1)) begin
                    state_d = ON;
                    ph_d    = '0;
                    tc_d    = '0;
                    tone_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chan_q  <= CH_NONE;
            beeps_q <= '0;
            ph_q    <= '0;
            tc_q    <= '0;
            tone_q  <= 1'b0;
            beep_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            beeps_q <= beeps_d;
            ph_q    <= ph_d;
            tc_q    <= tc_d;
            tone_q  <= tone_d;
            beep_q  <= state_d == ON;
        end
    end

`ifdef BUZZER_TONE_GEN_MUTE_EN
    logic tone_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_out_q <= 1'b0;
        end else if (ena) begin
            tone_out_q <= tone_d & ~mute;
        end
    end

    assign tone_out = tone_out_q;
`else
    assign tone_out = tone_q;
`endif

    assign beep_out = beep_q;
    assign chan_out = chan_q;

endmodule

// File: doc/buzzer_tone_gen.md
# buzzer_tone_gen

Downstream stage of the sensor-alarm detector: converts its three one-hot buzzer levels into an audible square-wave tone on a single piezo pin. Each alarm channel gets a distinct pitch and beep cadence (channel n sounds n beeps per burst), so the source is identifiable by ear. A tick prescaler sets the time base; a four-state cadence FSM sequences beeps, gaps and preemption.

## Interface
- PRESCALE, 256: clk cycles per tick; legal values ≥ 1.
- TONE_HALF1 / TONE_HALF2 / TONE_HALF3, 8 / 6 / 4: tone half-period in ticks per channel; legal values ≥ 1.
- BEEP_ON, 32: ticks per beep.
- BEEP_OFF, 16: ticks between beeps inside a burst.
- GAP, 64: ticks of silence after the last beep of a burst.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  high = run; low = freeze all state, outputs hold.
- alarm_in  input  3  buzzer levels from detector; bit0 = channel 1 … bit2 = channel 3.
- tone_out  output  1  square-wave drive to piezo.
- beep_out  output  1  envelope; high while FSM in ON.
- chan_out  output  2  active channel, 0 = none, 1..3.

## Operation
- Reset: FSM IDLE, all counters 0; tone_out = 0, beep_out = 0, chan_out = 0.
- Priority: highest set bit of alarm_in wins (3 > 2 > 1).
- IDLE: alarm_in ≠ 0 → ON with chan = winner, beep count = 0, prescaler and tone phase cleared.
- ON: tone_out starts 1 and toggles every TONE_HALFchan ticks. After BEEP_ON ticks: beep count + 1; if it equals chan → GAP, else → OFF.
- OFF: tone_out = 0. After BEEP_OFF ticks → ON, with tone phase reset to high.
- GAP: tone_out = 0. After GAP ticks: alarm_in ≠ 0 → ON with a freshly re-evaluated winner; else → IDLE.
- alarm_in = 0 in ON/OFF/GAP → IDLE on the next clk edge; burst abandoned.
- Preemption: in ON/OFF/GAP, a winner with priority above chan → ON with the new chan on the next edge. Beep count, prescaler and tone phase are cleared.
- A lower-priority change (chan's bit still set) is ignored until the GAP exit. If chan's bit drops while a lower bit is set, treat it as preemption to the new winner.
- tone_out is 0 and beep_out is 0 outside ON; chan_out is 0 only in IDLE.
- ena low: no counter, prescaler or state change. Transitions and input sampling resume on the first clk with ena high.

## Timing
- All outputs are registered. alarm_in is sampled on clk and assumed already synchronous.
- Latency: alarm_in seen in IDLE at edge k → state ON, beep_out = 1, tone_out = 1, chan_out valid after edge k.
- Tick: prescaler counts 0..PRESCALE-1 and emits a one-cycle tick at PRESCALE-1. PRESCALE = 1 gives a tick every cycle.
- Phase counters count ticks from 0 and transition or toggle on the tick that reaches limit-1. With PRESCALE = 1, ON lasts exactly BEEP_ON clk cycles.
- Counter widths are $clog2(max parameter + 1). No wrap is reachable because counters clear on every limit.
- Simultaneous tick-limit and preemption in the same cycle: preemption wins.
- Reset asserted mid-burst: all outputs go to 0 immediately (asynchronous).

## Configuration
- BUZZER_TONE_GEN_MUTE_EN defined: adds input port mute (1 bit, after alarm_in). While mute = 1, tone_out is forced 0 via a register. The FSM, beep_out and chan_out run unchanged.
- Not defined: no mute port; tone_out behaves as above.

## Structure
- Package buzzer_pkg holds:
  - FSM state enum: IDLE = 0, ON = 1, OFF = 2, GAP = 3.
  - Channel constants CH_NONE = 0 through CH_3 = 3.
  - A function mapping alarm_in to its winner.
- Sub-module tick_prescaler has inputs clk, rst_n, ena, clr and output tick; it is reused by the other alarm stages.
- The FSM, beep counter and tone phase counter live in buzzer_tone_gen.

## Test plan
Bench overrides: PRESCALE = 1, TONE_HALF1/2/3 = 4/3/2, BEEP_ON = 8, BEEP_OFF = 4, GAP = 10.
- Reset: rst_n low, alarm_in = 3'b111 → tone_out, beep_out, chan_out all 0 throughout.
- Channel 1: alarm_in = 3'b001 held → one beep per burst. tone_out = 11110000 over 8 cycles, then 10 cycles of 0, then repeats; chan_out = 1.
- Channel 3: alarm_in = 3'b100 → three beeps of tone 11001100. Beeps are separated by 4-cycle gaps, followed by a 10-cycle gap; beep_out pulses high for 8 cycles three times.
- Preemption: alarm_in = 3'b001, then 3'b011 at cycle 5 of the first beep → on the next edge chan_out = 2, tone_out restarts with pattern 111000, and the beep count is cleared.
- Drop and freeze:
  - alarm_in → 0 mid-ON → IDLE and outputs 0 on the next edge.
  - ena low for 20 cycles mid-beep → outputs frozen, then the beep resumes with its remaining ticks.
- Mute (BUZZER_TONE_GEN_MUTE_EN): mute = 1 with alarm_in = 3'b010 → tone_out stays 0 while beep_out still shows the two beeps.
